pla_b11_sched: RTL and testbench
================================

# pla_b11_sched

Round-robin scheduler that shares one combinational b11 PLA decoder instance (8 inputs x0..x7, 31 outputs z00..z30) among NREQ requesters. Each accepted request's 8-bit input vector is held on the decoder inputs for a programmable settling window. The 31-bit result is registered and returned with a valid/ready handshake tagged by requester ID. The block sits between the requesting control units and the single decoder, so that decoder is never duplicated.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- DEC_LAT, 0, extra settling cycles allowed for the decoder before capture (0..15)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  request pending, per requester
- req_x  in  8*NREQ  input vector; requester i at bits [8i+7:8i], bit 0 = x0
- req_ready  out  NREQ  one-hot accept strobe (combinational from req_valid and state)
- dec_x  out  8  drive to shared decoder x7..x0
- dec_z  in  31  decoder result z30..z00
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  3  index of the requester being answered
- rsp_z  out  31  registered decoder result
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: if any req_valid is high, the arbiter grants g, the first index with req_valid set, searching upward from (last_grant+1) mod NREQ.
  - req_ready[g] is asserted in that same cycle.
  - x_q <= req_x[g] and id_q <= g.
  - cnt <= DEC_LAT; next state is WAIT.
- WAIT: dec_x = x_q. While cnt != 0, cnt decrements. When cnt == 0, z_q <= dec_z and the next state is RESP.
- RESP: rsp_valid = 1; rsp_id = id_q; rsp_z = z_q. These stay stable until rsp_ready. On the handshake: last_grant <= id_q, next state is IDLE.
- dec_x always equals x_q, in every state.
- The block does not track its own response: a requester may hold req_valid, and it is re-arbitrated normally.
- All 31 dec_z bits are captured verbatim, including z00, which is constant 0.
- Reset values:
  - state = IDLE; x_q = 0; id_q = 0; z_q = 0; cnt = 0.
  - last_grant = NREQ-1, so index 0 wins first.
  - All outputs are 0.
- Reset mid-operation: an in-flight request is dropped with no response, and the requester must reissue it. Reset also clears the cache.
- Simultaneous requests are resolved purely by rotating priority, and no requester waits more than NREQ-1 grants.
- req_valid changes outside IDLE are ignored.

## Timing
- The accept cycle is T, in IDLE.
- WAIT occupies cycles T+1 .. T+1+DEC_LAT.
- rsp_valid rises at T+DEC_LAT+2.
- With rsp_ready held high, the next accept is at T+DEC_LAT+3, giving a throughput of one request per DEC_LAT+3 cycles.
- rsp_ready stalls extend RESP indefinitely without altering rsp_z or rsp_id.
- req_ready is never asserted outside IDLE, and never for more than one requester at a time.

## Configuration
- PLA_B11_SCHED_CACHE_EN defined: a one-entry result cache (cache_v, cache_x, cache_z) is compiled in.
  - Every WAIT capture loads the cache with x_q and dec_z.
  - In IDLE, if cache_v and req_x[g] == cache_x, the FSM goes directly to RESP with z_q <= cache_z. rsp_valid then rises at T+1 and dec_x is unchanged.
  - rst clears cache_v.
- Undefined: no cache; every request passes through WAIT.

## Test plan
- Reset, then a single request from req 0 with x=8'h06 and DEC_LAT=0 -> rsp_valid at T+2, rsp_id=0, rsp_z=31'h10010208; busy is 0 after the handshake.
- x=8'h00 from req 2 with DEC_LAT=3 -> rsp_valid at T+5, rsp_z=31'h00088020, and dec_x=8'h00 throughout WAIT.
- All four requesters valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0 and one response every DEC_LAT+3 cycles.
- rsp_ready held low for 10 cycles in RESP -> rsp_z/rsp_id stable, no req_ready pulses, response completes on release.
- rst asserted during WAIT -> next cycle state is IDLE, rsp_valid=0, dec_x=0; the reissued request completes normally.
- With CACHE_EN, two back-to-back requests with x=8'h06 -> the second responds at T+1 with 31'h10010208. Without CACHE_EN -> the second responds at T+DEC_LAT+2.

Source files
------------

// File: rtl/pla_b11_sched.sv
// Round-robin scheduler sharing one b11 PLA decoder among NREQ requesters.
// Optional one-entry result cache: define PLA_B11_SCHED_CACHE_EN.
module pla_b11_sched #(
    parameter int NREQ    = 4,
    parameter int DEC_LAT = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [8*NREQ-1:0]   req_x,
    output logic [NREQ-1:0]     req_ready,
    output logic [7:0]          dec_x,
    input  logic [30:0]         dec_z,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [2:0]          rsp_id,
    output logic [30:0]         rsp_z,
    output logic                busy
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state;
    logic [7:0]  x_q;
    logic [2:0]  id_q;
    logic [30:0] z_q;
    logic [3:0]  cnt;
    logic [2:0]  last_grant;

    logic        found;
    logic [2:0]  gnt;
    logic [7:0]  sel_x;
    int          idx;
    logic        hit;
    logic [30:0] hit_z;

    assign dec_x  = x_q;
    assign rsp_id = id_q;
    assign rsp_z  = z_q;

    // Rotating-priority search starting just after the last granted index
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        sel_x = '0;
        idx   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last_grant) + k) % NREQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                gnt   = 3'(idx);
                sel_x = req_x[idx*8 +: 8];
            end
        end
    end

    // One-hot accept strobe, only while idle and out of reset
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (state == IDLE && found && !rst && gnt == 3'(i))
                req_ready[i] = 1'b1;
        end
    end

`ifdef PLA_B11_SCHED_CACHE_EN
    logic        cache_v;
    logic [7:0]  cache_x;
    logic [30:0] cache_z;

    assign hit   = cache_v && (sel_x == cache_x);
    assign hit_z = cache_z;

    // Remember the most recent decoder capture
    always_ff @(posedge clk) begin
        if (rst) begin
            cache_v <= 1'b0;
            cache_x <= '0;
            cache_z <= '0;
        end else if (state == WAIT && cnt == 4'd0) begin
            cache_v <= 1'b1;
            cache_x <= x_q;
            cache_z <= dec_z;
        end
    end
`else
    assign hit   = 1'b0;
    assign hit_z = '0;
`endif

    // Main control FSM with registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            x_q        <= '0;
            id_q       <= '0;
            z_q        <= '0;
            cnt        <= '0;
            last_grant <= 3'(NREQ - 1);
            rsp_valid  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        id_q <= gnt;
                        busy <= 1'b1;
                        if (hit) begin
                            z_q       <= hit_z;
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end else begin
                            x_q   <= sel_x;
                            cnt   <= 4'(DEC_LAT);
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        z_q       <= dec_z;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        last_grant <= id_q;
                        rsp_valid  <= 1'b0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pla_b11_sched.sv
// Directed self-checking bench for pla_b11_sched.
// Honours PLA_B11_SCHED_CACHE_EN for cache-hit timing.
module tb_pla_b11_sched;

    localparam int NREQ = 4;
    localparam int LAT  = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_x;
    logic [NREQ-1:0]   req_ready;
    logic [7:0]        dec_x;
    logic [30:0]       dec_z;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [2:0]        rsp_id;
    logic [30:0]       rsp_z;
    logic              busy;

    int n_checks = 0;
    int n_fail   = 0;

    pla_b11_sched #(.NREQ(NREQ), .DEC_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_x(req_x), .req_ready(req_ready),
        .dec_x(dec_x), .dec_z(dec_z),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_z(rsp_z), .busy(busy)
    );

    always #5 clk = ~clk;

    // Stand-in for the shared decoder: two known b11 rows, synthetic elsewhere
    function automatic logic [30:0] pla(input logic [7:0] x);
        case (x)
            8'h06:   pla = 31'h10010208;
            8'h00:   pla = 31'h00088020;
            default: pla = {~x[6:0], x, ~x, x[7:1], 1'b0};
        endcase
    endfunction

    always_comb dec_z = pla(dec_x);

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called in the accept cycle; returns edges until rsp_valid (or -1)
    task automatic wait_rsp(output int n, input bit clr,
                            input bit chkx, input logic [7:0] x);
        n = 0;
        do begin
            step();
            n++;
            if (clr) req_valid = '0;
            if (chkx && !rsp_valid) chk("dec_x_wait", 32'(dec_x), 32'(x));
        end while (!rsp_valid && n < 40);
        if (!rsp_valid) n = -1;
    endtask

    int n;
    int g;
    logic [7:0] xs [NREQ];
    logic [31:0] exp_n;

    initial begin
        xs[0] = 8'h11; xs[1] = 8'h22; xs[2] = 8'h33; xs[3] = 8'h44;
        rst = 1'b1; req_valid = '0; req_x = '0; rsp_ready = 1'b0;
        step(); step();
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_dec_x", 32'(dec_x), 32'd0);
        chk("rst_rsp_z", 32'(rsp_z), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;

        // Single request, req 0, x=06
        req_valid = 4'b0001; req_x[7:0] = 8'h06;
        #1;
        chk("t1_req_ready", 32'(req_ready), 32'b0001);
        wait_rsp(n, 1'b1, 1'b1, 8'h06);
        chk("t1_latency", 32'(n), 32'(LAT + 2));
        chk("t1_rsp_id", 32'(rsp_id), 32'd0);
        chk("t1_rsp_z", 32'(rsp_z), 32'h10010208);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("t1_busy_after", 32'(busy), 32'd0);
        chk("t1_valid_after", 32'(rsp_valid), 32'd0);

        // Request from req 2, x=00
        req_valid = 4'b0100; req_x[23:16] = 8'h00;
        #1;
        chk("t2_req_ready", 32'(req_ready), 32'b0100);
        wait_rsp(n, 1'b1, 1'b1, 8'h00);
        chk("t2_latency", 32'(n), 32'(LAT + 2));
        chk("t2_rsp_id", 32'(rsp_id), 32'd2);
        chk("t2_rsp_z", 32'(rsp_z), 32'h00088020);

        // Stall in RESP while all requesters are pending
        for (int i = 0; i < NREQ; i++) req_x[i*8 +: 8] = xs[i];
        req_valid = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("stall_req_ready", 32'(req_ready), 32'd0);
            chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("stall_rsp_id", 32'(rsp_id), 32'd2);
            chk("stall_rsp_z", 32'(rsp_z), 32'h00088020);
            step();
        end
        rsp_ready = 1'b1;
        step();

        // Continuous requests: rotation continues after last grant 2
        for (int i = 0; i < 5; i++) begin
            g = (3 + i) % NREQ;
            chk("rr_req_ready", 32'(req_ready), 32'(1 << g));
            wait_rsp(n, 1'b0, 1'b1, xs[g]);
            chk("rr_latency", 32'(n), 32'(LAT + 2));
            chk("rr_rsp_id", 32'(rsp_id), 32'(g));
            chk("rr_rsp_z", 32'(rsp_z), 32'(pla(xs[g])));
            step();
        end
        req_valid = '0;
        rsp_ready = 1'b0;
        step();
        chk("rr_idle_busy", 32'(busy), 32'd0);

        // Reset during WAIT drops the request
        req_valid = 4'b0010; req_x[15:8] = 8'h55;
        #1;
        chk("rw_req_ready", 32'(req_ready), 32'b0010);
        step();
        req_valid = '0;
        chk("rw_busy_wait", 32'(busy), 32'd1);
        step();
        rst = 1'b1;
        step();
        chk("rw_busy", 32'(busy), 32'd0);
        chk("rw_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rw_dec_x", 32'(dec_x), 32'd0);
        chk("rw_req_ready_rst", 32'(req_ready), 32'd0);
        rst = 1'b0;
        req_valid = 4'b0010;
        #1;
        chk("rw_reissue_ready", 32'(req_ready), 32'b0010);
        wait_rsp(n, 1'b1, 1'b1, 8'h55);
        chk("rw_latency", 32'(n), 32'(LAT + 2));
        chk("rw_rsp_id", 32'(rsp_id), 32'd1);
        chk("rw_rsp_z", 32'(rsp_z), 32'(pla(8'h55)));
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // Back-to-back identical requests (cache hit when compiled in)
        req_valid = 4'b0001; req_x[7:0] = 8'h06;
        #1;
        chk("c1_req_ready", 32'(req_ready), 32'b0001);
        wait_rsp(n, 1'b0, 1'b1, 8'h06);
        chk("c1_latency", 32'(n), 32'(LAT + 2));
        chk("c1_rsp_z", 32'(rsp_z), 32'h10010208);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("c2_req_ready", 32'(req_ready), 32'b0001);
        wait_rsp(n, 1'b1, 1'b1, 8'h06);
`ifdef PLA_B11_SCHED_CACHE_EN
        exp_n = 32'd1;
`else
        exp_n = 32'(LAT + 2);
`endif
        chk("c2_latency", 32'(n), exp_n);
        chk("c2_rsp_id", 32'(rsp_id), 32'd0);
        chk("c2_rsp_z", 32'(rsp_z), 32'h10010208);
        chk("c2_dec_x", 32'(dec_x), 32'h06);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("c2_busy_after", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
